// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and register-control outputs of the
// pipeline stall/flush controller, bundled as one interface.
// master = the controller, slave = the pipeline datapath that it steers.
interface pipeline_ctrl_if;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        ifid_uses_rs1;
    logic        ifid_uses_rs2;
    logic [4:0]  idex_rd;
    logic        idex_mem_read;
    logic        ex_mispredict;
    logic        ex_busy;
    logic        imem_read;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_resp;

    logic        pc_load;
    logic        ifid_load;
    logic        idex_load;
    logic        exmem_load;
    logic        memwb_load;
    logic        ifid_rst;
    logic        idex_rst;
    logic [1:0]  ctrl_state;
    logic        stall_timeout;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushes;
    logic [31:0] perf_bubbles;

    modport master (
        input  ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
        input  idex_rd, idex_mem_read, ex_mispredict, ex_busy,
        input  imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
        output ifid_rst, idex_rst, ctrl_state, stall_timeout,
        output perf_stall_cycles, perf_flushes, perf_bubbles
    );

    modport slave (
        output ifid_rs1, ifid_rs2, ifid_uses_rs1, ifid_uses_rs2,
        output idex_rd, idex_mem_read, ex_mispredict, ex_busy,
        output imem_read, imem_resp, dmem_read, dmem_write, dmem_resp,
        input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
        input  ifid_rst, idex_rst, ctrl_state, stall_timeout,
        input  perf_stall_cycles, perf_flushes, perf_bubbles
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for a 5-stage pipeline.
// Resolves memory/EX freezes, load-use bubbles and mispredict squashes,
// defers a redirect that arrives while a memory access is in flight, and
// raises a sticky flag when the pipeline stays frozen too long.
// Optional feature: define PIPELINE_CTRL_PERF_EN to build the three
// performance counters; otherwise the perf ports read 0.
module pipeline_ctrl #(
    parameter int unsigned STALL_TIMEOUT = 1023
) (
    input logic            clk,
    input logic            rst_n,
    pipeline_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STALL      = 2'd1,
        FLUSH_WAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_FREEZE   = 2'd1,
        ACT_BUBBLE   = 2'd2,
        ACT_REDIRECT = 2'd3
    } act_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(STALL_TIMEOUT);

    // Freeze-run counter increment that holds at the timeout limit.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v >= TIMEOUT_LIM) ? TIMEOUT_LIM : v + 16'd1;
    endfunction

    state_t      state;
    state_t      state_next;
    state_t      run_next;
    act_t        act;
    act_t        run_act;
    logic        mem_stall;
    logic        load_use;
    logic [15:0] timeout_cnt;
    logic [15:0] timeout_inc;
    logic        timeout_flag;

    logic pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic ifid_rst, idex_rst;

    assign mem_stall = (bus.imem_read & ~bus.imem_resp)
                     | ((bus.dmem_read | bus.dmem_write) & ~bus.dmem_resp)
                     | bus.ex_busy;

    assign load_use = bus.idex_mem_read & (bus.idex_rd != 5'd0) &
                      ((bus.ifid_uses_rs1 & (bus.ifid_rs1 == bus.idex_rd)) |
                       (bus.ifid_uses_rs2 & (bus.ifid_rs2 == bus.idex_rd)));

    // Priority decision used in RUN and when a stall has just cleared.
    always_comb begin
        run_act  = ACT_ADVANCE;
        run_next = RUN;
        if (bus.ex_mispredict && mem_stall) begin
            run_act  = ACT_FREEZE;
            run_next = FLUSH_WAIT;
        end else if (bus.ex_mispredict) begin
            run_act  = ACT_REDIRECT;
        end else if (mem_stall) begin
            run_act  = ACT_FREEZE;
            run_next = STALL;
        end else if (load_use) begin
            run_act  = ACT_BUBBLE;
        end
    end

    // Next-state and action selection; FLUSH_WAIT remembers the mispredict.
    always_comb begin
        state_next = state;
        act        = ACT_ADVANCE;
        unique case (state)
            FLUSH_WAIT: begin
                if (mem_stall) begin
                    act = ACT_FREEZE;
                end else begin
                    act        = ACT_REDIRECT;
                    state_next = RUN;
                end
            end
            STALL: begin
                if (mem_stall) begin
                    act = ACT_FREEZE;
                end else begin
                    act        = run_act;
                    state_next = run_next;
                end
            end
            default: begin
                act        = run_act;
                state_next = run_next;
            end
        endcase
    end

    // State register; reset discards any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Register control decode; reset holds all loads off and flushes IF/ID, ID/EX.
    always_comb begin
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_rst   = 1'b0;
        idex_rst   = 1'b0;
        if (!rst_n) begin
            ifid_rst = 1'b1;
            idex_rst = 1'b1;
        end else begin
            unique case (act)
                ACT_ADVANCE: begin
                    pc_load    = 1'b1;
                    ifid_load  = 1'b1;
                    idex_load  = 1'b1;
                    exmem_load = 1'b1;
                    memwb_load = 1'b1;
                end
                ACT_BUBBLE: begin
                    idex_load  = 1'b1;
                    idex_rst   = 1'b1;
                    exmem_load = 1'b1;
                    memwb_load = 1'b1;
                end
                ACT_REDIRECT: begin
                    pc_load    = 1'b1;
                    ifid_rst   = 1'b1;
                    idex_rst   = 1'b1;
                    exmem_load = 1'b1;
                    memwb_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign timeout_inc = sat_inc(timeout_cnt);

    // Consecutive-freeze counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt  <= 16'd0;
            timeout_flag <= 1'b0;
        end else if (act == ACT_FREEZE) begin
            timeout_cnt  <= timeout_inc;
            timeout_flag <= timeout_flag | (timeout_inc == TIMEOUT_LIM);
        end else begin
            timeout_cnt  <= 16'd0;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic [31:0] perf_bubble_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q  <= 32'd0;
            perf_flush_q  <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            if (act == ACT_FREEZE)   perf_stall_q  <= perf_stall_q + 32'd1;
            if (act == ACT_REDIRECT) perf_flush_q  <= perf_flush_q + 32'd1;
            if (act == ACT_BUBBLE)   perf_bubble_q <= perf_bubble_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = perf_stall_q;
    assign bus.perf_flushes      = perf_flush_q;
    assign bus.perf_bubbles      = perf_bubble_q;
`else
    assign bus.perf_stall_cycles = 32'd0;
    assign bus.perf_flushes      = 32'd0;
    assign bus.perf_bubbles      = 32'd0;
`endif

    assign bus.pc_load       = pc_load;
    assign bus.ifid_load     = ifid_load;
    assign bus.idex_load     = idex_load;
    assign bus.exmem_load    = exmem_load;
    assign bus.memwb_load    = memwb_load;
    assign bus.ifid_rst      = ifid_rst;
    assign bus.idex_rst      = idex_rst;
    assign bus.ctrl_state    = state;
    assign bus.stall_timeout = timeout_flag;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios followed by random hazard traffic,
// each cycle compared against a behavioural model of the controller rules.
module tb_pipeline_ctrl;

    localparam int TMO = 8;

    localparam logic [6:0] C_ADV = 7'b1111100;
    localparam logic [6:0] C_FRZ = 7'b0000000;
    localparam logic [6:0] C_BUB = 7'b0011101;
    localparam logic [6:0] C_RDR = 7'b1001111;
    localparam logic [6:0] C_RST = 7'b0000011;

    logic clk = 1'b0;
    logic rst_n;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(.STALL_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // behavioural model: pending redirect, stalled, freeze run length, counters
    bit          m_pending;
    bit          m_stall;
    int          m_run;
    bit          m_flag;
    logic [31:0] m_pstall, m_pflush, m_pbub;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [6:0] ctl_vec();
        return {bus.pc_load, bus.ifid_load, bus.idex_load, bus.exmem_load,
                bus.memwb_load, bus.ifid_rst, bus.idex_rst};
    endfunction

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PIPELINE_CTRL_PERF_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd1;
`endif
    endfunction

    task automatic model_reset();
        m_pending = 0; m_stall = 0; m_run = 0; m_flag = 0;
        m_pstall = 0; m_pflush = 0; m_pbub = 0;
    endtask

    task automatic set_idle();
        bus.ifid_rs1 = 5'd0; bus.ifid_rs2 = 5'd0;
        bus.ifid_uses_rs1 = 1'b0; bus.ifid_uses_rs2 = 1'b0;
        bus.idex_rd = 5'd0; bus.idex_mem_read = 1'b0;
        bus.ex_mispredict = 1'b0; bus.ex_busy = 1'b0;
        bus.imem_read = 1'b0; bus.imem_resp = 1'b0;
        bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; bus.dmem_resp = 1'b0;
    endtask

    // Check one cycle against the model, clock it, then advance the model.
    task automatic cycle(input string tag);
        bit ms, lu, mp, np, nst;
        logic [6:0] exp_ctl;
        logic [1:0] exp_state;
        #1;
        ms = (bus.imem_read && !bus.imem_resp) ||
             ((bus.dmem_read || bus.dmem_write) && !bus.dmem_resp) || bus.ex_busy;
        lu = bus.idex_mem_read && bus.idex_rd != 0 &&
             ((bus.ifid_uses_rs1 && bus.ifid_rs1 == bus.idex_rd) ||
              (bus.ifid_uses_rs2 && bus.ifid_rs2 == bus.idex_rd));
        mp = bus.ex_mispredict;
        exp_state = m_pending ? 2'd2 : (m_stall ? 2'd1 : 2'd0);
        np = 0; nst = 0;
        if (m_pending) begin
            exp_ctl = ms ? C_FRZ : C_RDR; np = ms;
        end else if (m_stall && ms) begin
            exp_ctl = C_FRZ; nst = 1;
        end else if (mp && ms) begin
            exp_ctl = C_FRZ; np = 1;
        end else if (mp) begin
            exp_ctl = C_RDR;
        end else if (ms) begin
            exp_ctl = C_FRZ; nst = 1;
        end else if (lu) begin
            exp_ctl = C_BUB;
        end else begin
            exp_ctl = C_ADV;
        end
        chk({tag, ".ctl"}, 32'(ctl_vec()), 32'(exp_ctl));
        chk({tag, ".state"}, 32'(bus.ctrl_state), 32'(exp_state));
        chk({tag, ".timeout"}, 32'(bus.stall_timeout), 32'(m_flag));
        chk({tag, ".perf_stall"}, bus.perf_stall_cycles, perf_exp(m_pstall));
        chk({tag, ".perf_flush"}, bus.perf_flushes, perf_exp(m_pflush));
        chk({tag, ".perf_bubble"}, bus.perf_bubbles, perf_exp(m_pbub));
        @(posedge clk);
        if (exp_ctl == C_FRZ) begin
            m_run++; m_pstall++;
            if (m_run >= TMO) m_flag = 1;
        end else begin
            m_run = 0;
        end
        if (exp_ctl == C_RDR) m_pflush++;
        if (exp_ctl == C_BUB) m_pbub++;
        m_pending = np; m_stall = nst;
        @(negedge clk);
    endtask

    // Assert reset a little after the falling edge and check held outputs.
    task automatic apply_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".ctl"}, 32'(ctl_vec()), 32'(C_RST));
        chk({tag, ".state"}, 32'(bus.ctrl_state), 32'd0);
        chk({tag, ".timeout"}, 32'(bus.stall_timeout), 32'd0);
        chk({tag, ".perf_stall"}, bus.perf_stall_cycles, 32'd0);
        chk({tag, ".perf_flush"}, bus.perf_flushes, 32'd0);
        chk({tag, ".perf_bubble"}, bus.perf_bubbles, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        model_reset();
        @(negedge clk);
        apply_reset("rst0");
        cycle("idle");

        // load-use on rs2, then one-cycle bubble only
        bus.idex_mem_read = 1'b1; bus.idex_rd = 5'd5;
        bus.ifid_rs2 = 5'd5; bus.ifid_uses_rs2 = 1'b1;
        cycle("lu_bubble");
        bus.idex_mem_read = 1'b0;
        cycle("lu_after");
        bus.idex_mem_read = 1'b1; bus.idex_rd = 5'd0; bus.ifid_rs2 = 5'd0;
        cycle("lu_x0");
        set_idle();

        // mispredict with idle memory
        bus.ex_mispredict = 1'b1;
        cycle("mp_idle");
        bus.ex_mispredict = 1'b0;
        cycle("mp_after");

        // deferred redirect behind an outstanding fetch
        bus.imem_read = 1'b1; bus.ex_mispredict = 1'b1;
        cycle("defer0");
        bus.ex_mispredict = 1'b0;
        cycle("defer1");
        cycle("defer2");
        bus.imem_resp = 1'b1;
        cycle("defer_rdr");
        set_idle();
        cycle("defer_after");

        // data stall: four freezes then response
        bus.dmem_read = 1'b1;
        for (int i = 0; i < 4; i++) cycle("dstall");
        bus.dmem_resp = 1'b1;
        cycle("dstall_resp");
        set_idle();
        cycle("dstall_after");

        // both responses in the same cycle
        bus.imem_read = 1'b1; bus.dmem_write = 1'b1;
        cycle("both_wait");
        bus.imem_resp = 1'b1; bus.dmem_resp = 1'b1;
        cycle("both_resp");
        set_idle();

        // timeout: ex_busy held past the limit, flag stays after release
        bus.ex_busy = 1'b1;
        for (int i = 0; i < TMO + 3; i++) cycle("tmo_busy");
        bus.ex_busy = 1'b0;
        cycle("tmo_rel0");
        cycle("tmo_rel1");

        // reset while a redirect is pending
        bus.imem_read = 1'b1; bus.ex_mispredict = 1'b1;
        cycle("fw_enter");
        bus.ex_mispredict = 1'b0;
        cycle("fw_hold");
        apply_reset("rst_fw");
        bus.imem_read = 1'b0;
        cycle("fw_post_rst");

        // random hazard traffic
        for (int i = 0; i < 600; i++) begin
            bus.ifid_rs1      = 5'($urandom_range(0, 3));
            bus.ifid_rs2      = 5'($urandom_range(0, 3));
            bus.ifid_uses_rs1 = 1'($urandom_range(0, 1));
            bus.ifid_uses_rs2 = 1'($urandom_range(0, 1));
            bus.idex_rd       = 5'($urandom_range(0, 3));
            bus.idex_mem_read = 1'($urandom_range(0, 1));
            bus.ex_mispredict = ($urandom_range(0, 5) == 0);
            bus.ex_busy       = ($urandom_range(0, 7) == 0);
            bus.imem_read     = 1'($urandom_range(0, 1));
            bus.imem_resp     = 1'($urandom_range(0, 1));
            bus.dmem_read     = ($urandom_range(0, 3) == 0);
            bus.dmem_write    = ($urandom_range(0, 5) == 0);
            bus.dmem_resp     = 1'($urandom_range(0, 1));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
